// File: rtl/hot_key_buffer.sv
// hot_key_buffer: captures hot keys reported by the count-min sketch,
// suppresses re-reports of recently captured keys through a small recent-key
// filter, queues accepted entries in a first-word-fall-through FIFO toward
// the host drain logic, and keeps saturating profiling counters.
module hot_key_buffer #(
   parameter int KEY_WIDTH    = 32,
   parameter int CNT_WIDTH    = 16,
   parameter int FIFO_DEPTH   = 64,
   parameter int FILTER_DEPTH = 8,
   parameter int STAT_WIDTH   = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          hot_valid_i,
   input  logic [KEY_WIDTH-1:0]          key_i,
   input  logic [CNT_WIDTH-1:0]          cnt_i,
   input  logic                          clear_i,
   input  logic                          filter_en_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [KEY_WIDTH-1:0]          out_key_o,
   output logic [CNT_WIDTH-1:0]          out_cnt_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic [STAT_WIDTH-1:0]         accepted_cnt_o,
   output logic [STAT_WIDTH-1:0]         dup_cnt_o,
   output logic [STAT_WIDTH-1:0]         drop_cnt_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_DEPTH-1);
   localparam logic [FW-1:0] FLT_ONE  = FW'(1);

   typedef struct packed {
      logic [KEY_WIDTH-1:0] key;
      logic [CNT_WIDTH-1:0] cnt;
   } entry_t;

   entry_t                               mem [FIFO_DEPTH];
   entry_t                               head_e;
   logic [AW-1:0]                        head, tail;
   logic [AW:0]                          level;
   logic [FILTER_DEPTH-1:0][KEY_WIDTH-1:0] flt_key;
   logic [FILTER_DEPTH-1:0]              flt_vld;
   logic [FILTER_DEPTH-1:0]              flt_hit;
   logic [FW-1:0]                        flt_ptr;
   logic                                 flush, dup, full, pop, push;
   logic                                 dup_evt, drop_evt;
   logic [STAT_WIDTH-1:0]                acc_q, dup_q, drop_q;

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (v == '1) ? v : v + STAT_WIDTH'(1);
   endfunction

   // One comparator per filter slot; only valid slots can match.
   for (genvar i = 0; i < FILTER_DEPTH; i++) begin : g_flt
      assign flt_hit[i] = flt_vld[i] && (flt_key[i] == key_i);
   end

   assign flush       = rst || clear_i;
   assign dup         = filter_en_i && (|flt_hit);
   assign out_valid_o = (level != '0);
   assign full        = (level == LVL_FULL);
   assign pop         = out_valid_o && out_ready_i;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push        = hot_valid_i && !dup && (!full || pop);
   assign dup_evt     = hot_valid_i && dup;
   assign drop_evt    = hot_valid_i && !dup && full && !pop;

   assign head_e    = mem[head];
   assign out_key_o = out_valid_o ? head_e.key : '0;
   assign out_cnt_o = out_valid_o ? head_e.cnt : '0;
   assign level_o   = level;

   assign accepted_cnt_o = acc_q;
   assign dup_cnt_o      = dup_q;
   assign drop_cnt_o     = drop_q;

   // Entry storage; contents need no reset because reads are gated by level.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[tail] <= '{key: key_i, cnt: cnt_i};
   end

   // Head/tail pointers wrap naturally; occupancy lives only in level.
   always_ff @(posedge clk) begin
      if (flush) begin
         head  <= '0;
         tail  <= '0;
         level <= '0;
      end else begin
         if (push) tail <= tail + PTR_ONE;
         if (pop)  head <= head + PTR_ONE;
         unique case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Recent-key filter: round-robin overwrite of the oldest slot on accept.
   always_ff @(posedge clk) begin
      if (flush) begin
         flt_vld <= '0;
         flt_ptr <= '0;
      end else if (push) begin
         flt_key[flt_ptr] <= key_i;
         flt_vld[flt_ptr] <= 1'b1;
         flt_ptr          <= (flt_ptr == FLT_LAST) ? '0 : flt_ptr + FLT_ONE;
      end
   end

   // Saturating profiling counters.
   always_ff @(posedge clk) begin
      if (flush) begin
         acc_q  <= '0;
         dup_q  <= '0;
         drop_q <= '0;
      end else begin
         if (push)     acc_q  <= sat_inc(acc_q);
         if (dup_evt)  dup_q  <= sat_inc(dup_q);
         if (drop_evt) drop_q <= sat_inc(drop_q);
      end
   end

endmodule

// File: tb/tb_hot_key_buffer.sv
// Scoreboard bench for hot_key_buffer: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_hot_key_buffer;

   localparam int FIFO_DEPTH   = 64;
   localparam int FILTER_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hot_valid_i = 1'b0;
   logic [31:0] key_i = '0;
   logic [15:0] cnt_i = '0;
   logic        clear_i = 1'b0;
   logic        filter_en_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_key_o;
   logic [15:0] out_cnt_o;
   logic [6:0]  level_o;
   logic [31:0] accepted_cnt_o, dup_cnt_o, drop_cnt_o;

   hot_key_buffer dut (
      .clk(clk), .rst(rst), .hot_valid_i(hot_valid_i), .key_i(key_i), .cnt_i(cnt_i),
      .clear_i(clear_i), .filter_en_i(filter_en_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .out_key_o(out_key_o), .out_cnt_o(out_cnt_o),
      .level_o(level_o), .accepted_cnt_o(accepted_cnt_o), .dup_cnt_o(dup_cnt_o),
      .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct { bit [31:0] k; bit [15:0] c; } ent_t;

   // Reference model state (values as seen after the most recent edge).
   ent_t        exp_q[$];
   bit [31:0]   m_recent[$];
   int          m_level = 0;
   int unsigned m_acc = 0, m_dup = 0, m_drop = 0;
   bit          mon_en = 1'b0;
   int          checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned sinc(input int unsigned v);
      return (v == 32'hFFFF_FFFF) ? v : v + 1;
   endfunction

   // Drive one cycle of stimulus, predict its effect, advance past the edge.
   task automatic step(input bit hv, input bit [31:0] k, input bit [15:0] c,
                       input bit clr, input bit fen, input bit rdy, input bit r = 1'b0);
      int          n_level;
      int unsigned n_acc, n_dup, n_drop;
      bit          pop, hit, accept;
      hot_valid_i = hv; key_i = k; cnt_i = c; clear_i = clr;
      filter_en_i = fen; out_ready_i = rdy; rst = r;
      n_level = m_level; n_acc = m_acc; n_dup = m_dup; n_drop = m_drop;
      if (r || clr) begin
         n_level = 0; n_acc = 0; n_dup = 0; n_drop = 0;
         exp_q.delete();
         m_recent.delete();
      end else begin
         pop = (m_level > 0) && rdy;
         hit = 1'b0;
         foreach (m_recent[i]) if (m_recent[i] == k) hit = 1'b1;
         hit = hit && fen;
         accept = 1'b0;
         if (hv) begin
            if (hit) n_dup = sinc(n_dup);
            else if (m_level == FIFO_DEPTH && !pop) n_drop = sinc(n_drop);
            else accept = 1'b1;
         end
         if (accept) begin
            n_acc = sinc(n_acc);
            exp_q.push_back('{k: k, c: c});
            m_recent.push_back(k);
            if (m_recent.size() > FILTER_DEPTH) void'(m_recent.pop_front());
         end
         n_level = m_level + int'(accept) - int'(pop);
      end
      @(posedge clk);
      #1;
      m_level = n_level; m_acc = n_acc; m_dup = n_dup; m_drop = n_drop;
   endtask

   // Monitor: compares registered status every cycle, and the head entry
   // against the scoreboard whenever the DUT presents one.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("level", level_o, m_level);
         chk("out_valid", out_valid_o, m_level != 0);
         chk("accepted_cnt", accepted_cnt_o, m_acc);
         chk("dup_cnt", dup_cnt_o, m_dup);
         chk("drop_cnt", drop_cnt_o, m_drop);
         if (!rst && !clear_i) begin
            if (out_valid_o) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL sb_unexpected actual key=%0h expected=no entry", out_key_o);
               end else begin
                  chk("head_key", out_key_o, exp_q[0].k);
                  chk("head_cnt", out_cnt_o, exp_q[0].c);
                  if (out_ready_i) void'(exp_q.pop_front());
               end
            end else begin
               chk("empty_key", out_key_o, 0);
               chk("empty_cnt", out_cnt_o, 0);
            end
         end
      end
   end

   initial begin
      bit [31:0] k;
      int        ph, rp;
      #1;
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);
      mon_en = 1'b1;
      step(0, 0, 0, 0, 1, 0);
      chk("reset_level", level_o, 0);
      chk("reset_valid", out_valid_o, 0);
      chk("reset_acc", accepted_cnt_o, 0);

      // Three distinct keys, consumer stalled.
      step(1, 32'h100, 5, 0, 1, 0);
      step(1, 32'h200, 6, 0, 1, 0);
      step(1, 32'h300, 7, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("t1_level", level_o, 3);
      chk("t1_head_key", out_key_o, 32'h100);
      chk("t1_head_cnt", out_cnt_o, 5);
      chk("t1_acc", accepted_cnt_o, 3);

      // Duplicate suppression on, then off.
      step(0, 0, 0, 1, 1, 0);
      step(1, 32'h100, 1, 0, 1, 0);
      step(1, 32'h100, 2, 0, 1, 0);
      chk("t2_dup", dup_cnt_o, 1);
      chk("t2_level", level_o, 1);
      step(0, 0, 0, 1, 0, 0);
      step(1, 32'h100, 1, 0, 0, 0);
      step(1, 32'h100, 2, 0, 0, 0);
      chk("t2b_dup", dup_cnt_o, 0);
      chk("t2b_level", level_o, 2);

      // Oldest filter entry evicted after FILTER_DEPTH+1 accepts.
      step(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 9; i++) step(1, 32'h700 + i, 16'(i), 0, 1, 0);
      step(1, 32'h700, 16'h55, 0, 1, 0);
      chk("t3_acc", accepted_cnt_o, 10);
      chk("t3_dup", dup_cnt_o, 0);

      // Full FIFO: drop, then accept with a same-cycle pop.
      step(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 64; i++) step(1, 32'h1000 + i, 16'(i), 0, 1, 0);
      chk("t4_full_level", level_o, 64);
      step(1, 32'h1040, 16'h40, 0, 1, 0);
      chk("t4_drop", drop_cnt_o, 1);
      chk("t4_level", level_o, 64);
      step(1, 32'h1041, 16'h41, 0, 1, 1);
      chk("t4_level_pp", level_o, 64);
      chk("t4_acc", accepted_cnt_o, 65);
      chk("t4_head_adv", out_key_o, 32'h1001);

      // Streaming push/pop across pointer wrap.
      step(0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 200; i++) begin
         step(1, 32'h8000 + i, 16'(i * 3), 0, 1, 1);
         if (level_o > 1) chk("t5_level_le1", level_o, 1);
      end
      step(0, 0, 0, 0, 1, 1);
      chk("t5_acc", accepted_cnt_o, 200);
      chk("t5_drop", drop_cnt_o, 0);

      // Clear with a concurrent report; filtered key accepted afterwards.
      step(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) step(1, 32'h2000 + i, 16'(i), 0, 1, 0);
      step(1, 32'h2009, 16'h9, 0, 1, 0);
      chk("t6_dup_pre", dup_cnt_o, 1);
      step(1, 32'h2009, 16'h9, 1, 1, 0);
      chk("t6_level", level_o, 0);
      chk("t6_valid", out_valid_o, 0);
      chk("t6_acc", accepted_cnt_o, 0);
      chk("t6_dup", dup_cnt_o, 0);
      step(1, 32'h2009, 16'h9, 0, 1, 0);
      chk("t6_reaccept", accepted_cnt_o, 1);
      step(0, 0, 0, 0, 1, 0);

      // Randomized traffic with varying drain pressure.
      for (int i = 0; i < 4000; i++) begin
         ph = i / 1000;
         rp = (ph == 0) ? 70 : (ph == 1) ? 10 : (ph == 2) ? 50 : 90;
         k = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h5000 + $urandom_range(0, 15);
         step($urandom_range(0, 99) < 80, k, 16'($urandom()),
              $urandom_range(0, 299) == 0,
              (ph == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
              $urandom_range(0, 99) < rp,
              $urandom_range(0, 699) == 0);
      end
      step(0, 0, 0, 0, 1, 1);
      mon_en = 1'b0;
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
